// File: rtl/vector_pkg.sv
// Shared constants, memory-map bounds and state encoding for the vector memory unit.
// The address window helper is used by the address generator's legality flags.
package vector_pkg;

   localparam int LANES = 4;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int CW    = $clog2(LANES + 1);
   localparam int LB    = $clog2(LANES);

   localparam logic [AW-1:0] ROM_LO  = 32'd400;
   localparam logic [AW-1:0] SENO_LO = 32'd90400;
   localparam logic [AW-1:0] RAM_LO  = 32'd90700;
   localparam logic [AW-1:0] MAP_HI  = 32'd220300;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } vmu_state_t;

   function automatic logic in_window(input logic [AW-1:0] addr,
                                      input logic [AW-1:0] lo,
                                      input logic [AW-1:0] hi);
      return (addr >= lo) && (addr < hi);
   endfunction

endpackage

// File: rtl/vmu_addr_gen.sv
// Element address accumulator: loads base on command accept, adds the stride per element
// (wrapping modulo 2^AW) and flags whether the current address is legal for loads/stores.
module vmu_addr_gen
   import vector_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic          step_i,
   input  logic [AW-1:0] base_i,
   input  logic [AW-1:0] stride_i,
   output logic [AW-1:0] addr_o,
   output logic          load_ok_o,
   output logic          store_ok_o
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] stride_q, stride_d;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      addr_d   = addr_q;
      stride_d = stride_q;
      if (load_i) begin
         addr_d   = base_i;
         stride_d = stride_i;
      end else if (step_i) begin
         addr_d = addr_q + stride_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q   <= '0;
         stride_q <= '0;
      end else begin
         addr_q   <= addr_d;
         stride_q <= stride_d;
      end
   end

   assign addr_o     = addr_q;
   assign load_ok_o  = in_window(addr_q, ROM_LO, MAP_HI);
   assign store_ok_o = in_window(addr_q, RAM_LO, MAP_HI);

endmodule

// File: rtl/vector_mem_unit.sv
// Vector load/store initiator: walks base/stride/vlen one word per cycle toward the memory
// controller, gathering load words into lanes and flagging accesses outside the legal map.
module vector_mem_unit
   import vector_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                is_store,
   input  logic [AW-1:0]       base_addr,
   input  logic [AW-1:0]       stride,
   input  logic [2:0]          vlen,
   input  logic [LANES*DW-1:0] store_data,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [LANES*DW-1:0] load_data,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wd,
   output logic                mem_we,
   input  logic [DW-1:0]       mem_rd
);

   vmu_state_t state_q;
   logic       busy_q, done_q;

   logic [CW-1:0]            idx_q, idx_d;
   logic [CW-1:0]            vlen_q, vlen_d;
   logic                     is_store_q, is_store_d;
   logic [LANES-1:0][DW-1:0] store_data_q, store_data_d;
   logic [LANES-1:0][DW-1:0] load_data_q, load_data_d;
   logic                     err_q, err_d;

   logic          accept, in_access, last_elem, step;
   logic [CW-1:0] vlen_clamp;
   logic [LB-1:0] lane;
   logic [AW-1:0] elem_addr;
   logic          load_ok, store_ok, elem_ok;

   assign accept     = (state_q == IDLE) && start;
   assign in_access  = (state_q == ACCESS);
   assign vlen_clamp = (CW'(vlen) > CW'(LANES)) ? CW'(LANES) : CW'(vlen);
   assign last_elem  = (idx_q == (vlen_q - CW'(1)));
   assign lane       = idx_q[LB-1:0];
   assign elem_ok    = is_store_q ? store_ok : load_ok;

   vmu_addr_gen u_addr_gen (
      .clk       (clk),
      .reset     (reset),
      .load_i    (accept),
      .step_i    (step),
      .base_i    (base_addr),
      .stride_i  (stride),
      .addr_o    (elem_addr),
      .load_ok_o (load_ok),
      .store_ok_o(store_ok)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q <= 1'b1;
                  if (vlen_clamp == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (last_elem) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Element counter, error flag and load gather; lanes past vlen keep the zeros from accept.
   always_comb begin
      idx_d        = idx_q;
      vlen_d       = vlen_q;
      is_store_d   = is_store_q;
      store_data_d = store_data_q;
      load_data_d  = load_data_q;
      err_d        = err_q;
      step         = 1'b0;
      if (accept) begin
         idx_d        = '0;
         vlen_d       = vlen_clamp;
         is_store_d   = is_store;
         store_data_d = store_data;
         load_data_d  = '0;
         err_d        = 1'b0;
      end else if (in_access) begin
         idx_d = idx_q + CW'(1);
         step  = 1'b1;
         if (!elem_ok) begin
            err_d = 1'b1;
         end
         if (!is_store_q) begin
            load_data_d[lane] = load_ok ? mem_rd : '0;
         end
      end
   end

   // NOTE: load_data is a visible output, so this lane array is reset like any other register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q        <= '0;
         vlen_q       <= '0;
         is_store_q   <= 1'b0;
         store_data_q <= '0;
         load_data_q  <= '0;
         err_q        <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         vlen_q       <= vlen_d;
         is_store_q   <= is_store_d;
         store_data_q <= store_data_d;
         load_data_q  <= load_data_d;
         err_q        <= err_d;
      end
   end

   // Bus is gated by the registered state so an async reset silences it in the same cycle.
   assign mem_addr  = in_access ? elem_addr : '0;
   assign mem_we    = in_access && is_store_q && store_ok;
   assign mem_wd    = (in_access && is_store_q) ? store_data_q[lane] : '0;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign load_data = load_data_q;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed bench for vector_mem_unit with a small memoryController model (ROM/SENO patterns,
// RAM array) and one task per scenario doing its own inline comparisons.
module tb_vector_mem_unit;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          is_store = 1'b0;
   logic [31:0]   base_addr = '0;
   logic [31:0]   stride = '0;
   logic [2:0]    vlen = '0;
   logic [127:0]  store_data = '0;
   logic          busy, done, err, mem_we;
   logic [127:0]  load_data;
   logic [31:0]   mem_addr, mem_wd, mem_rd;

   int n_cmp = 0;
   int n_mis = 0;
   int we_count = 0;

   always #5 clk = ~clk;

   vector_mem_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_store  (is_store),
      .base_addr (base_addr),
      .stride    (stride),
      .vlen      (vlen),
      .store_data(store_data),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .load_data (load_data),
      .mem_addr  (mem_addr),
      .mem_wd    (mem_wd),
      .mem_we    (mem_we),
      .mem_rd    (mem_rd)
   );

   // Memory model: ROM 400.. reads A0000000+addr, SENO reads 5E000000+addr, first 128 RAM
   // words start as CC000000+offset (stored XOR-ed so a zeroed array means "untouched").
   logic [31:0] ram [128] = '{default: 32'h0};
   logic [31:0] ram_off, ram_pat;
   logic        ram_hit;
   assign ram_off = mem_addr - 32'd90700;
   assign ram_hit = (mem_addr >= 32'd90700) && (mem_addr < 32'd90828);
   assign ram_pat = 32'hCC00_0000 | {25'd0, ram_off[6:0]};

   always_comb begin
      mem_rd = '0;
      if (mem_addr >= 32'd400 && mem_addr < 32'd90400) mem_rd = 32'hA000_0000 + mem_addr;
      else if (mem_addr >= 32'd90400 && mem_addr < 32'd90700) mem_rd = 32'h5E00_0000 + mem_addr;
      else if (ram_hit) mem_rd = ram[ram_off[6:0]] ^ ram_pat;
   end

   always @(posedge clk) begin
      if (mem_we) begin
         we_count <= we_count + 1;
         if (ram_hit) ram[ram_off[6:0]] <= mem_wd ^ ram_pat;
      end
   end

   task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] strd,
                        input logic [2:0] len, input logic [127:0] sd);
      @(negedge clk);
      is_store   = st;
      base_addr  = base;
      stride     = strd;
      vlen       = len;
      store_data = sd;
      start      = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if ({busy, done, err, mem_we} !== 4'b0) begin n_mis++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, mem_we}); end
      n_cmp++; if (mem_addr !== 32'd0 || mem_wd !== 32'd0) begin n_mis++; $display("FAIL reset_bus: got addr %0d wd %h want 0 0", mem_addr, mem_wd); end
      n_cmp++; if (load_data !== 128'd0) begin n_mis++; $display("FAIL reset_load_data: got %h want 0", load_data); end
      reset = 1'b0;
   endtask

   task automatic test_load_rom();
      issue(1'b0, 32'd400, 32'd1, 3'd4, 128'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_addr !== 32'd400 + 32'(i)) begin n_mis++; $display("FAIL t1_addr[%0d]: got %0d want %0d", i, mem_addr, 400 + i); end
         n_cmp++; if ({busy, done, mem_we} !== 3'b100) begin n_mis++; $display("FAIL t1_ctl[%0d]: got %b want 100", i, {busy, done, mem_we}); end
      end
      @(negedge clk);
      n_cmp++; if ({busy, done, err} !== 3'b110) begin n_mis++; $display("FAIL t1_done: got %b want 110", {busy, done, err}); end
      n_cmp++; if (load_data !== 128'hA0000193_A0000192_A0000191_A0000190) begin n_mis++; $display("FAIL t1_data: got %h want A0000193A0000192A0000191A0000190", load_data); end
      @(negedge clk);
      n_cmp++; if ({busy, done} !== 2'b00) begin n_mis++; $display("FAIL t1_idle: got %b want 00", {busy, done}); end
      n_cmp++; if (load_data !== 128'hA0000193_A0000192_A0000191_A0000190) begin n_mis++; $display("FAIL t1_hold: got %h", load_data); end
   endtask

   task automatic test_store_ram();
      logic [31:0] exp_wd [3];
      exp_wd = '{32'h11, 32'h22, 32'h33};
      issue(1'b1, 32'd90700, 32'd2, 3'd3, 128'hDEADBEEF_00000033_00000022_00000011);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_addr !== 32'd90700 + 32'(2 * i)) begin n_mis++; $display("FAIL t2_addr[%0d]: got %0d want %0d", i, mem_addr, 90700 + 2 * i); end
         n_cmp++; if (mem_we !== 1'b1 || mem_wd !== exp_wd[i]) begin n_mis++; $display("FAIL t2_wr[%0d]: got we %b wd %h want 1 %h", i, mem_we, mem_wd, exp_wd[i]); end
      end
      @(negedge clk);
      n_cmp++; if ({done, err, mem_we} !== 3'b100 || load_data !== 128'd0) begin n_mis++; $display("FAIL t2_done: got %b data %h want 100 0", {done, err, mem_we}, load_data); end
      issue(1'b0, 32'd90700, 32'd2, 3'd3, 128'd0);
      repeat (4) @(negedge clk);
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_mis++; $display("FAIL t2_rd_done: got done %b err %b want 1 0", done, err); end
      n_cmp++; if (load_data !== 128'h00000000_00000033_00000022_00000011) begin n_mis++; $display("FAIL t2_readback: got %h want 0...33_22_11", load_data); end
   endtask

   task automatic test_store_illegal();
      int we_before;
      we_before = we_count;
      issue(1'b1, 32'd90400, 32'd1, 3'd2, 128'h0_0000_0000_0000_0000_0000_AAAA_5555);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 32'd90400 + 32'(i)) begin n_mis++; $display("FAIL t3_bus[%0d]: got we %b addr %0d want 0 %0d", i, mem_we, mem_addr, 90400 + i); end
      end
      @(negedge clk);
      n_cmp++; if ({done, err} !== 2'b11) begin n_mis++; $display("FAIL t3_err: got %b want 11", {done, err}); end
      @(negedge clk);
      n_cmp++; if (err !== 1'b1 || we_count !== we_before) begin n_mis++; $display("FAIL t3_sticky: got err %b we %0d want 1 %0d", err, we_count, we_before); end
   endtask

   task automatic test_neg_stride();
      issue(1'b0, 32'd90701, 32'hFFFF_FFFF, 3'd3, 128'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (mem_addr !== 32'd90701 - 32'(i)) begin n_mis++; $display("FAIL t4_addr[%0d]: got %0d want %0d", i, mem_addr, 90701 - i); end
      end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_mis++; $display("FAIL t4_done: got done %b err %b want 1 0", done, err); end
      n_cmp++; if (load_data !== 128'h00000000_5E01624B_00000011_CC000001) begin n_mis++; $display("FAIL t4_data: got %h want 000000005E01624B00000011CC000001", load_data); end
      issue(1'b0, 32'd1, 32'hFFFF_FFFF, 3'd2, 128'd0);
      @(negedge clk);
      n_cmp++; if (mem_addr !== 32'd1) begin n_mis++; $display("FAIL t4_wrap_addr: got %0d want 1", mem_addr); end
      repeat (2) @(negedge clk);
      n_cmp++; if ({done, err} !== 2'b11 || load_data !== 128'd0) begin n_mis++; $display("FAIL t4_wrap: got %b data %h want 11 0", {done, err}, load_data); end
   endtask

   task automatic test_vlen_edges();
      int done_cnt;
      issue(1'b1, 32'd90700, 32'd1, 3'd0, 128'h1234);
      @(negedge clk);
      n_cmp++; if ({busy, done, err, mem_we} !== 4'b1100 || mem_addr !== 32'd0) begin n_mis++; $display("FAIL t5_vlen0: got %b addr %0d want 1100 0", {busy, done, err, mem_we}, mem_addr); end
      @(negedge clk);
      n_cmp++; if ({busy, done} !== 2'b00) begin n_mis++; $display("FAIL t5_vlen0_end: got %b want 00", {busy, done}); end
      // start pulses while busy and while in DONE must be ignored
      issue(1'b0, 32'd400, 32'd1, 3'd4, 128'd0);
      done_cnt = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (c == 5) begin
            n_cmp++; if (done !== 1'b1) begin n_mis++; $display("FAIL t5_done_time: got %b want 1", done); end
         end
         if (c == 2 || c == 5) begin start = 1'b1; base_addr = 32'h5000; end
         if (c == 3 || c == 6) start = 1'b0;
      end
      n_cmp++; if (done_cnt !== 1) begin n_mis++; $display("FAIL t5_done_count: got %0d want 1", done_cnt); end
      n_cmp++; if (busy !== 1'b0 || load_data !== 128'hA0000193_A0000192_A0000191_A0000190) begin n_mis++; $display("FAIL t5_ignored: got busy %b data %h", busy, load_data); end
      issue(1'b0, 32'd400, 32'd1, 3'd7, 128'd0);
      repeat (5) @(negedge clk);
      n_cmp++; if (done !== 1'b1 || load_data !== 128'hA0000193_A0000192_A0000191_A0000190) begin n_mis++; $display("FAIL t5_clamp: got done %b data %h", done, load_data); end
   endtask

   task automatic test_reset_abort();
      int we_before;
      we_before = we_count;
      issue(1'b1, 32'd90710, 32'd1, 3'd4, 128'h44444444_33333333_22222222_11111111);
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'd90710) begin n_mis++; $display("FAIL t6_e0: got we %b addr %0d want 1 90710", mem_we, mem_addr); end
      @(negedge clk);
      n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 32'd90711) begin n_mis++; $display("FAIL t6_e1: got we %b addr %0d want 1 90711", mem_we, mem_addr); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({busy, done, err, mem_we} !== 4'b0 || mem_addr !== 32'd0 || mem_wd !== 32'd0 || load_data !== 128'd0) begin n_mis++; $display("FAIL t6_abort: got %b addr %0d wd %h", {busy, done, err, mem_we}, mem_addr, mem_wd); end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_cmp++; if (we_count !== we_before + 1) begin n_mis++; $display("FAIL t6_we_count: got %0d want %0d", we_count - we_before, 1); end
      issue(1'b0, 32'd90710, 32'd1, 3'd4, 128'd0);
      repeat (5) @(negedge clk);
      n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_mis++; $display("FAIL t6_after_done: got done %b err %b want 1 0", done, err); end
      n_cmp++; if (load_data !== 128'hCC00000D_CC00000C_CC00000B_11111111) begin n_mis++; $display("FAIL t6_after_data: got %h want CC00000DCC00000CCC00000B11111111", load_data); end
   endtask

   initial begin
      test_reset();
      test_load_rom();
      test_store_ram();
      test_store_illegal();
      test_neg_stride();
      test_vlen_edges();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
